// File: rtl/alu_seq_core_if.sv
// alu_seq_core_if: operand/control inputs and result/flag/LED outputs of alu_seq_core
interface alu_seq_core_if #(parameter int WIDTH = 32);
    logic             start, busy, done;
    logic [3:0]       ALU_OP;
    logic [WIDTH-1:0] A, B, F, F_HI;
    logic [2:0]       F_LED_SW;
    logic             ZF, CF, OF, SF;
    logic [7:0]       LED;
    modport master(output start, ALU_OP, A, B, F_LED_SW,
                   input busy, done, F, F_HI, ZF, CF, OF, SF, LED);
    modport slave(input start, ALU_OP, A, B, F_LED_SW,
                  output busy, done, F, F_HI, ZF, CF, OF, SF, LED);
endinterface

// File: rtl/alu_seq_core.sv
// alu_seq_core: multi-cycle ALU with latched operands, iterative unsigned multiply,
// status flags, start/busy/done handshake and an LED byte-view mux
module alu_seq_core #(parameter int WIDTH = 32) (
    input logic clk,
    input logic rst,
    alu_seq_core_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, MUL, DONE} state_t;
    state_t           state, state_n;
    logic [3:0]       op;
    logic [WIDTH-1:0] a, b, ph, pl, res, mh, ml;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sum, dif, ps;
    logic             cf_c, of_c, accept, last;
    logic [63:0]      fx, hx;

    assign accept = (state == IDLE || state == DONE) && bus.start;
    assign last   = cnt == CW'(1);

    always_ff @(posedge clk) state <= rst ? IDLE : state_n;

    always_comb begin
        state_n = state;
        if (state == IDLE || state == DONE)
            state_n = bus.start ? (bus.ALU_OP == 4'b1000 ? MUL : CALC) : IDLE;
        else if (state == CALC || last)
            state_n = DONE;
    end

    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} - {1'b0, b};
    // One shift-add step: high half accumulates A when the low multiplier bit is set
    assign ps  = {1'b0, ph} + (pl[0] ? {1'b0, a} : '0);
    assign mh  = ps[WIDTH:1];
    assign ml  = {ps[0], pl[WIDTH-1:1]};

    always_comb begin
        res  = op[3]         ? '0 :
               op[2:0] == 0  ? a & b :
               op[2:0] == 1  ? a | b :
               op[2:0] == 2  ? a ^ b :
               op[2:0] == 3  ? ~(a | b) :
               op[2:0] == 4  ? sum[WIDTH-1:0] :
               op[2:0] == 5  ? dif[WIDTH-1:0] :
               op[2:0] == 6  ? WIDTH'($signed(a) < $signed(b)) :
                               a << b[SW-1:0];
        cf_c = op == 4'd4 ? sum[WIDTH] : op == 4'd5 ? dif[WIDTH] : 1'b0;
        of_c = op == 4'd4 ? (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]) :
               op == 4'd5 ? (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]) : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {bus.F, bus.F_HI, bus.ZF, bus.CF, bus.OF, bus.SF} <= '0;
            {a, b, op, ph, pl, cnt} <= '0;
        end else begin
            if (accept) begin
                a   <= bus.A;
                b   <= bus.B;
                op  <= bus.ALU_OP;
                cnt <= CW'(WIDTH);
                ph  <= '0;
                pl  <= bus.B;
            end
            if (state == CALC) begin
                bus.F    <= res;
                bus.F_HI <= '0;
                bus.ZF   <= res == '0;
                bus.CF   <= cf_c;
                bus.OF   <= of_c;
                bus.SF   <= res[WIDTH-1];
            end
            if (state == MUL) begin
                ph  <= mh;
                pl  <= ml;
                cnt <= cnt - 1'b1;
                if (last) begin
                    bus.F    <= ml;
                    bus.F_HI <= mh;
                    bus.ZF   <= {mh, ml} == '0;
                    bus.CF   <= |mh;
                    bus.OF   <= |mh;
                    bus.SF   <= mh[WIDTH-1];
                end
            end
        end
    end

    assign bus.busy = state == CALC || state == MUL;
    assign bus.done = state == DONE;
    // Zero-extend to 64 bits so byte selects beyond WIDTH/8 naturally read 0
    assign fx = 64'(bus.F);
    assign hx = 64'(bus.F_HI);
    assign bus.LED = bus.F_LED_SW == 3'b111 ? {4'b0, bus.ZF, bus.CF, bus.OF, bus.SF} :
                     bus.F_LED_SW[2]        ? 8'(hx >> {bus.F_LED_SW[1:0], 3'b000}) :
                                              8'(fx >> {bus.F_LED_SW[1:0], 3'b000});
endmodule

// File: doc/alu_seq_core.md
# alu_seq_core

Parametrised multi-cycle ALU core with registered operands, registered result and flags, a start/busy/done handshake, and an 8-bit LED byte-view mux. It generalises the 8-function board-experiment ALU in three ways: configurable word width, an iterative unsigned multiply with a double-width result, and a status flag register. It sits between the operand/switch front-end and the LED display. It can also serve as the execute unit of the multi-cycle CPU experiments.

## Interface
- WIDTH, 32, operand/result width; multiple of 8, range 8..64.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in IDLE or DONE.
- ALU_OP  in  4  operation code, latched on accept.
- A  in  WIDTH  operand A, latched on accept.
- B  in  WIDTH  operand B, latched on accept.
- F_LED_SW  in  3  LED view select.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when the result is valid.
- F  out  WIDTH  result, or low half of the product.
- F_HI  out  WIDTH  high half of the product; 0 for all other ops.
- ZF, CF, OF, SF  out  1 each  status flags.
- LED  out  8  selected byte view.

## Operation
- States: IDLE, CALC, MUL, DONE. Reset → IDLE.
- **IDLE/DONE, start=1:** latch A, B, ALU_OP.
  - Go to CALC if ALU_OP[3]=0 or ALU_OP is reserved.
  - Go to MUL with cnt=WIDTH if ALU_OP=1000.
- **IDLE/DONE, start=0:** go to (or stay in) IDLE.
- **CALC:** compute, write F/F_HI/flags, go to DONE.
- **MUL:** one shift-add step per cycle; cnt decrements. On the step where cnt reaches 0, write F/F_HI/flags and go to DONE.
- **DONE:** lasts exactly one cycle unless start is re-asserted.
- Op codes:
  - 0000 AND.
  - 0001 OR.
  - 0010 XOR.
  - 0011 NOR.
  - 0100 ADD.
  - 0101 SUB (A−B).
  - 0110 SLT: signed, F = 1 or 0.
  - 0111 SLL: F = A << B[log2(WIDTH)-1:0].
  - 1000 MULU: {F_HI,F} = A×B, unsigned.
  - 1001–1111 reserved: F=0, F_HI=0, ZF=1, other flags 0.
- Arithmetic is modulo 2^WIDTH. F_HI=0 for every op except MULU.
- Flags are written together with F:
  - ZF: F==0; for MULU, the whole {F_HI,F}==0.
  - SF: F[WIDTH-1]; for MULU, F_HI[WIDTH-1].
  - CF: ADD carry-out; SUB borrow (A<B unsigned); MULU F_HI≠0; 0 otherwise.
  - OF: signed overflow for ADD/SUB; MULU F_HI≠0; 0 otherwise.
- start while in CALC or MUL is ignored. Latched operands do not change.
- Input changes on A/B/ALU_OP outside the accept edge have no effect.
- LED is combinational from registered outputs:
  - 0xx: byte xx of F (bytes at or beyond WIDTH/8 read 0).
  - 100–110: bytes 0–2 of F_HI.
  - 111: {4'b0, ZF, CF, OF, SF}.

## Timing
- Reset values: F=0, F_HI=0, all flags=0, busy=0, done=0, LED=0, state IDLE.
- rst has priority over start. rst mid-operation aborts it: no done, outputs cleared at that edge.
- Notation: accept edge = edge k.
- **Logic/ADD/SUB/SLT/SLL/reserved:**
  - busy=1 after edge k.
  - Results plus done=1, busy=0 after edge k+1. Latency is 1 cycle.
- **MULU:**
  - busy=1 after edges k..k+WIDTH−1.
  - Results plus done=1, busy=0 after edge k+WIDTH. Latency is WIDTH cycles.
- done is high for exactly one cycle per accepted operation.
- F and flags hold their values until the next result write or reset.
- **Back-to-back:** start=1 in DONE is accepted at that edge. done drops and busy rises after that edge. Throughput is one op per 2 cycles (single-cycle ops).
- busy and done are never high together.

## Test plan
All scenarios use WIDTH=32.
- **ADD overflow:** A=0x7FFFFFFF, B=1, start one cycle → after edge k+1: F=0x80000000, SF=1, OF=1, CF=0, ZF=0, done=1 for one cycle.
- **SUB zero and borrow:** SUB 5−5 → F=0, ZF=1, CF=0. SUB 0−1 → F=0xFFFFFFFF, CF=1, SF=1, OF=0.
- **MULU max:** A=B=0xFFFFFFFF → busy 32 cycles; after edge k+32: F=0x00000001, F_HI=0xFFFFFFFE, CF=OF=1, SF=1. Re-pulse start with AND mid-multiply → ignored; result unchanged.
- **Back-to-back and SLT/SLL:** SLT A=0xFFFFFFFF, B=0 gives F=1. Assert start again in DONE with SLL A=1, B=35 → F=0x00000008 two edges later; done pulses twice.
- **Reset mid-MULU:** rst at edge k+10 → after that edge F=F_HI=0, flags=0, busy=0, LED=0, no done pulse. A new start afterwards completes normally.
- **LED view:** F=0x12345678 via OR A=0x12345678, B=0. Sweep F_LED_SW 000..011 → LED=0x78, 0x56, 0x34, 0x12. 100 → 0x00. 111 → 0x00 (flags all 0).
